mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 15, meaning bus cycles allowed per transfer before abort (only used when ARB_TIMEOUT_EN is defined; legal range 1..15).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset: asynchronous and active-high (`RstEnable` = 1).
REQ-004 SHALL have ports if_req (in, 1, fetch request), if_addr (in, 32, fetch address), if_rdata (out, 32, fetch data), if_ack (out, 1, fetch done).
REQ-005 SHALL have ports mem_req (in, 1), mem_we (in, 1), mem_addr (in, 32), mem_wdata (in, 32), mem_sel (in, 4, byte enables), mem_rdata (out, 32), mem_ack (out, 1); all belong to the load/store stage.
REQ-006 SHALL have bus ports bus_req (out, 1), bus_we (out, 1), bus_addr (out, 32), bus_wdata (out, 32), bus_sel (out, 4), bus_rdata (in, 32), bus_ack (in, 1).
REQ-007 SHALL have ports stallreq_if (out, 1) and stallreq_mem (out, 1), feeding the pipeline controller that builds stall[5:0].
REQ-008 SHALL have port bus_err (out, 1), a one-cycle abort pulse.

Function
REQ-009 SHALL implement the states IDLE, IF_XFER and MEM_XFER.
REQ-010 In IDLE with mem_req=1, the next state SHALL be MEM_XFER; otherwise, with if_req=1, it SHALL be IF_XFER; otherwise it SHALL remain IDLE.
REQ-011 SHALL always give mem_req priority over if_req when both are high in IDLE, because the load/store instruction is the older one.
REQ-012 On each grant, the winner's addr, we, wdata and sel SHALL be latched into registers; bus_* outputs SHALL be driven only from these registers, and bus_we=0 SHALL hold for IF.
REQ-013 bus_req SHALL be 1 only in the XFER states.
REQ-014 In an XFER state with bus_ack=1, the owner's ack SHALL be 1 and its rdata SHALL equal bus_rdata in the same cycle (combinational), and the next state SHALL be IDLE.
REQ-015 The non-owner's ack SHALL be 0 and its rdata SHALL be `ZeroWord`; outside the ack cycle all rdata SHALL be `ZeroWord`.
REQ-016 Minimum latency: request seen in IDLE at cycle n, bus_req high at n+1, ack at the earliest at n+1, next grant at the earliest at n+2.
REQ-017 stallreq_mem SHALL equal mem_req & ~mem_ack; stallreq_if SHALL equal if_req & ~if_ack.
REQ-018 If the owner drops its req mid-transfer, the transfer SHALL complete; the ack SHALL still pulse, and the requester is responsible for ignoring it.
REQ-019 Latched fields SHALL NOT change during XFER even if requester inputs change.

Reset
REQ-020 On rst=1, the state SHALL be IDLE and all latched fields and the timeout counter SHALL be 0.
REQ-021 During and after reset, bus_req, bus_we, bus_err, if_ack and mem_ack SHALL be 0, and all data/address outputs SHALL be `ZeroWord`.
REQ-022 Reset asserted mid-transfer SHALL abort immediately with no ack.

Configuration
REQ-023 With ARB_TIMEOUT_EN defined, a 4-bit counter SHALL clear on grant and increment each XFER cycle without bus_ack.
REQ-024 When the counter reaches TIMEOUT_CYCLES, the block SHALL force the owner's ack=1 with rdata=`ZeroWord`, pulse bus_err, and return to IDLE.
REQ-025 Without ARB_TIMEOUT_EN, the counter SHALL be absent, bus_err SHALL be tied to 0, and transfers SHALL wait indefinitely.

Structure
REQ-026 State encodings (2-bit) SHALL live in the shared defines package alongside `RstEnable`, `ZeroWord` and `RegBus`.
REQ-027 The block SHALL be a single module; the optional timeout counter SHALL stay inline, with no sub-module.

Verification
REQ-028 if_req=1, if_addr=0x00000100, bus acks 2 cycles after bus_req with 0x3C010001 -> if_ack one cycle, if_rdata=0x3C010001, stallreq_if=1 until then.
REQ-029 if_req and mem_req both rise in the same IDLE cycle (mem_we=1, addr 0x80, wdata 0xDEADBEEF, sel 0xF) -> bus_we=1, bus_addr=0x80 first; IF granted the cycle after mem_ack.
REQ-030 During MEM_XFER, change mem_addr 0x80->0x84 -> bus_addr stays 0x80 until ack.
REQ-031 Assert rst mid-IF_XFER -> bus_req=0 asynchronously, no if_ack, IDLE after release.
REQ-032 ARB_TIMEOUT_EN, TIMEOUT_CYCLES=3, bus_ack never rises -> after 3 XFER cycles, mem_ack=1, mem_rdata=0, bus_err=1 for one cycle; without the macro, stallreq_mem stays 1.
REQ-033 mem_req dropped one cycle after grant, bus_ack returns 0x12345678 -> mem_ack pulses once, state IDLE next cycle.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared defines for the instruction-fetch / load-store
// memory arbiter -- reset level, bus width, zero word, FSM state encoding
// and the latched bus command payload.
package mem_arbiter_pkg;

  localparam int unsigned RegBus = 32;  // data/address bus width
  localparam int unsigned SelW   = 4;   // byte-enable width
  localparam int unsigned CntW   = 4;   // timeout counter width

  localparam logic              RstEnable = 1'b1;
  localparam logic [RegBus-1:0] ZeroWord  = '0;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_IF_XFER  = 2'd1,
    ST_MEM_XFER = 2'd2
  } arb_state_e;

  // Command captured from the winning requester at grant time.
  typedef struct packed {
    logic              we;
    logic [RegBus-1:0] addr;
    logic [RegBus-1:0] wdata;
    logic [SelW-1:0]   sel;
  } bus_cmd_t;

endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory bus between instruction fetch (IF) and the
// load/store stage (MEM). MEM wins ties because it holds the older
// instruction. The winner's command is latched on grant and the bus is driven
// only from that copy; the owner's ack/rdata follow bus_ack combinationally.
//
// Ports:
//   clk, rst                        clock, async active-high reset
//   if_req/if_addr -> if_rdata/if_ack           fetch requester
//   mem_req/we/addr/wdata/sel -> mem_rdata/ack  load/store requester
//   bus_req/we/addr/wdata/sel, bus_rdata/ack    shared memory bus
//   stallreq_if, stallreq_mem       pipeline stall requests
//   bus_err                         one-cycle abort pulse (timeout build only)
//
// Build option: define ARB_TIMEOUT_EN to abort a transfer that sees no
// bus_ack within TIMEOUT_CYCLES cycles; otherwise transfers wait forever.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [RegBus-1:0] if_addr,
  output logic [RegBus-1:0] if_rdata,
  output logic              if_ack,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [RegBus-1:0] mem_addr,
  input  logic [RegBus-1:0] mem_wdata,
  input  logic [SelW-1:0]   mem_sel,
  output logic [RegBus-1:0] mem_rdata,
  output logic              mem_ack,
  output logic              bus_req,
  output logic              bus_we,
  output logic [RegBus-1:0] bus_addr,
  output logic [RegBus-1:0] bus_wdata,
  output logic [SelW-1:0]   bus_sel,
  input  logic [RegBus-1:0] bus_rdata,
  input  logic              bus_ack,
  output logic              stallreq_if,
  output logic              stallreq_mem,
  output logic              bus_err
);

  // Counter is 4 bits wide, so only 1..15 is meaningful.
  if (TIMEOUT_CYCLES == 0 || TIMEOUT_CYCLES > 15) begin : g_bad_timeout
    $error("mem_arbiter: TIMEOUT_CYCLES must be in 1..15");
  end

  arb_state_e state_q, state_d;
  bus_cmd_t   cmd_q, cmd_d;
  logic       in_xfer;
  logic       grant;
  logic       timeout_hit;
  logic       xfer_done;

  assign in_xfer   = (state_q != ST_IDLE);
  assign grant     = (state_q == ST_IDLE) && (mem_req || if_req);
  assign xfer_done = in_xfer && (bus_ack || timeout_hit);

  // State and latched command registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst == RstEnable) begin
      state_q <= ST_IDLE;
      cmd_q   <= '0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
    end
  end

  // Next state and grant-time command capture.
  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    case (state_q)
      ST_IDLE: begin
        if (mem_req) begin
          state_d = ST_MEM_XFER;
          cmd_d   = '{we: mem_we, addr: mem_addr, wdata: mem_wdata, sel: mem_sel};
        end else if (if_req) begin
          // Fetches are always full-word reads.
          state_d = ST_IF_XFER;
          cmd_d   = '{we: 1'b0, addr: if_addr, wdata: ZeroWord, sel: '1};
        end
      end
      ST_IF_XFER, ST_MEM_XFER: begin
        if (xfer_done) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Owner's ack/rdata; a timeout acks with ZeroWord since bus_ack is low then.
  always_comb begin
    if_ack    = 1'b0;
    mem_ack   = 1'b0;
    if_rdata  = ZeroWord;
    mem_rdata = ZeroWord;
    if (state_q == ST_IF_XFER) begin
      if_ack = xfer_done;
      if (bus_ack) if_rdata = bus_rdata;
    end
    if (state_q == ST_MEM_XFER) begin
      mem_ack = xfer_done;
      if (bus_ack) mem_rdata = bus_rdata;
    end
  end

  assign bus_req      = in_xfer;
  assign bus_we       = cmd_q.we;
  assign bus_addr     = cmd_q.addr;
  assign bus_wdata    = cmd_q.wdata;
  assign bus_sel      = cmd_q.sel;
  assign stallreq_if  = if_req & ~if_ack;
  assign stallreq_mem = mem_req & ~mem_ack;

`ifdef ARB_TIMEOUT_EN
  logic [CntW-1:0] cnt_q, cnt_d;

  assign timeout_hit = in_xfer && !bus_ack && (cnt_q == CntW'(TIMEOUT_CYCLES));
  assign bus_err     = timeout_hit;

  // Counts unacknowledged XFER cycles; cleared on every grant.
  always_comb begin
    cnt_d = cnt_q;
    if (grant) begin
      cnt_d = '0;
    end else if (in_xfer && !bus_ack && !timeout_hit) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst == RstEnable) cnt_q <= '0;
    else                  cnt_q <= cnt_d;
  end
`else
  assign timeout_hit = 1'b0;
  assign bus_err     = 1'b0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios plus randomized traffic, all checked
// against a transaction-level model of the arbiter (owner, captured command,
// cycles waited).
module tb_mem_arbiter;

`ifdef ARB_TIMEOUT_EN
  localparam bit          TO_EN = 1'b1;
  localparam int unsigned TB_TO = 3;
`else
  localparam bit          TO_EN = 1'b0;
  localparam int unsigned TB_TO = 15;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic [31:0] if_rdata;
  logic        if_ack;
  logic        mem_req = 1'b0;
  logic        mem_we = 1'b0;
  logic [31:0] mem_addr = '0;
  logic [31:0] mem_wdata = '0;
  logic [3:0]  mem_sel = '0;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_sel;
  logic [31:0] bus_rdata = '0;
  logic        bus_ack = 1'b0;
  logic        stallreq_if;
  logic        stallreq_mem;
  logic        bus_err;

  int n_checks = 0;
  int n_errors = 0;

  // Model: 0 = no owner, 1 = fetch owns bus, 2 = load/store owns bus.
  int          m_owner;
  logic        m_we;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [3:0]  m_sel;
  int          m_wait;
  bit          m_done;

  mem_arbiter #(.TIMEOUT_CYCLES(TB_TO)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_sel(mem_sel), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_sel(bus_sel), .bus_rdata(bus_rdata),
    .bus_ack(bus_ack),
    .stallreq_if(stallreq_if), .stallreq_mem(stallreq_mem), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = 0; m_we = 1'b0; m_addr = '0; m_wdata = '0; m_sel = '0;
    m_wait = 0; m_done = 1'b0;
  endtask

  // Called at posedge+1; compares all outputs mid-cycle against the model.
  task automatic sample();
    bit to, own_if, own_mem;
    #3;
    to      = TO_EN && (m_owner != 0) && !bus_ack && (m_wait == int'(TB_TO));
    m_done  = (m_owner != 0) && (bus_ack || to);
    own_if  = (m_owner == 1);
    own_mem = (m_owner == 2);
    check("bus_req",   32'(bus_req),   32'(m_owner != 0));
    check("bus_we",    32'(bus_we),    32'(m_we));
    check("bus_addr",  bus_addr,       m_addr);
    check("bus_wdata", bus_wdata,      m_wdata);
    check("bus_sel",   32'(bus_sel),   32'(m_sel));
    check("if_ack",    32'(if_ack),    32'(own_if && m_done));
    check("mem_ack",   32'(mem_ack),   32'(own_mem && m_done));
    check("if_rdata",  if_rdata,  (own_if  && bus_ack) ? bus_rdata : 32'h0);
    check("mem_rdata", mem_rdata, (own_mem && bus_ack) ? bus_rdata : 32'h0);
    check("stall_if",  32'(stallreq_if),  32'(if_req  && !(own_if  && m_done)));
    check("stall_mem", 32'(stallreq_mem), 32'(mem_req && !(own_mem && m_done)));
    check("bus_err",   32'(bus_err),      32'(to));
  endtask

  // Moves the model across the next rising edge, then returns at posedge+1.
  task automatic advance();
    if (m_owner == 0) begin
      if (mem_req) begin
        m_owner = 2; m_we = mem_we; m_addr = mem_addr; m_wdata = mem_wdata;
        m_sel = mem_sel; m_wait = 0;
      end else if (if_req) begin
        m_owner = 1; m_we = 1'b0; m_addr = if_addr; m_wdata = '0;
        m_sel = 4'hF; m_wait = 0;
      end
    end else if (m_done) begin
      m_owner = 0;
    end else begin
      m_wait++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    sample();
    advance();
  endtask

  initial begin
    model_reset();
    @(posedge clk);
    #1;
    // Outputs held quiet during reset.
    sample();
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Fetch with ack two cycles after bus_req.
    if_req = 1'b1; if_addr = 32'h0000_0100;
    tick();
    for (int k = 0; k < 2; k++) begin
      sample();
      check("t28_stall", 32'(stallreq_if), 32'h1);
      check("t28_addr",  bus_addr, 32'h0000_0100);
      advance();
    end
    bus_ack = 1'b1; bus_rdata = 32'h3C01_0001;
    sample();
    check("t28_ack",   32'(if_ack), 32'h1);
    check("t28_rdata", if_rdata,    32'h3C01_0001);
    advance();
    if_req = 1'b0; bus_ack = 1'b0;
    sample();
    check("t28_ackdone", 32'(if_ack), 32'h0);
    advance();

    // Simultaneous requests: store wins, address change ignored, fetch next.
    if_req = 1'b1; if_addr = 32'h0000_0300;
    mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h80;
    mem_wdata = 32'hDEAD_BEEF; mem_sel = 4'hF;
    tick();
    mem_addr = 32'h84;
    sample();
    check("t29_we",    32'(bus_we), 32'h1);
    check("t29_addr",  bus_addr,    32'h80);
    check("t29_wdata", bus_wdata,   32'hDEAD_BEEF);
    advance();
    bus_ack = 1'b1; bus_rdata = 32'h0;
    sample();
    check("t30_addr", bus_addr,     32'h80);
    check("t29_mack", 32'(mem_ack), 32'h1);
    advance();
    mem_req = 1'b0; mem_we = 1'b0; bus_ack = 1'b0;
    tick();
    sample();
    check("t29_ifgnt", 32'(bus_req), 32'h1);
    check("t29_ifwe",  32'(bus_we),  32'h0);
    check("t29_ifadr", bus_addr,     32'h0000_0300);
    advance();
    bus_ack = 1'b1; bus_rdata = 32'h1111_2222;
    tick();
    if_req = 1'b0; bus_ack = 1'b0;
    tick();

    // Load whose requester drops mid-transfer still completes.
    mem_req = 1'b1; mem_addr = 32'h40; mem_sel = 4'h3;
    tick();
    mem_req = 1'b0;
    sample();
    check("t33_busreq", 32'(bus_req), 32'h1);
    advance();
    bus_ack = 1'b1; bus_rdata = 32'h1234_5678;
    sample();
    check("t33_ack",   32'(mem_ack), 32'h1);
    check("t33_rdata", mem_rdata,    32'h1234_5678);
    advance();
    bus_ack = 1'b0;
    sample();
    check("t33_idle", 32'(bus_req), 32'h0);
    advance();

    // Bus never acks: timeout abort, or indefinite stall without it.
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h500; mem_sel = 4'hF;
    tick();
    for (int k = 0; k <= (TO_EN ? int'(TB_TO) : 19); k++) begin
      sample();
      check("t32_stall", 32'(stallreq_mem), 32'(!(TO_EN && k == int'(TB_TO))));
      check("t32_err",   32'(bus_err),      32'(TO_EN && k == int'(TB_TO)));
      advance();
    end
    mem_req = 1'b0; bus_ack = 1'b1; bus_rdata = 32'h5555_AAAA;
    tick();
    bus_ack = 1'b0;
    tick();

    // Asynchronous reset in the middle of a fetch.
    if_req = 1'b1; if_addr = 32'h0000_0200;
    tick();
    check("t31_pre", 32'(bus_req), 32'h1);
    bus_ack = 1'b1; bus_rdata = 32'hCAFE_F00D;
    #1;
    rst = 1'b1;
    #1;
    check("t31_busreq", 32'(bus_req), 32'h0);
    check("t31_ifack",  32'(if_ack),  32'h0);
    check("t31_rdata",  if_rdata,     32'h0);
    check("t31_addr",   bus_addr,     32'h0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0; if_req = 1'b0; bus_ack = 1'b0;
    tick();

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      if_req    = ($urandom_range(0, 3) != 0);
      if_addr   = $urandom;
      mem_req   = ($urandom_range(0, 2) == 0);
      mem_we    = $urandom_range(0, 1) == 1;
      mem_addr  = $urandom;
      mem_wdata = $urandom;
      mem_sel   = 4'($urandom_range(0, 15));
      bus_ack   = (m_owner != 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0);
      bus_rdata = $urandom;
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
